// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - shared Zicsr funct3 codes, FSM state type and op-bit positions
package csr_pkg;

    localparam logic [2:0] CSRRW  = 3'b001;
    localparam logic [2:0] CSRRS  = 3'b010;
    localparam logic [2:0] CSRRC  = 3'b011;
    localparam logic [2:0] CSRRWI = 3'b101;
    localparam logic [2:0] CSRRSI = 3'b110;
    localparam logic [2:0] CSRRCI = 3'b111;

    localparam int OP_R = 1;
    localparam int OP_W = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/csr_op_decode.sv
// rtl/csr_op_decode.sv - combinational R/W op derivation and illegal-funct3 detection
module csr_op_decode
    import csr_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic [4:0] rs1_idx,
    input  logic [4:0] rd_idx,
    output logic [1:0] op,
    output logic       illegal
);

    always_comb begin
        op      = 2'b00;
        illegal = 1'b0;
        unique case (funct3)
            CSRRW, CSRRWI: begin
                op[OP_R] = (rd_idx != 5'd0);
                op[OP_W] = 1'b1;
            end
            // rs1_idx doubles as uimm for the immediate forms, so one test covers both
            CSRRS, CSRRC, CSRRSI, CSRRCI: begin
                op[OP_R] = 1'b1;
                op[OP_W] = (rs1_idx != 5'd0);
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/csr_req_ctrl.sv
// rtl/csr_req_ctrl.sv - single-outstanding CSR request issue/response stage
// Optional response watchdog enabled by defining CSR_TIMEOUT_EN.
module csr_req_ctrl
    import csr_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int REG_WIDTH   = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_funct3,
    input  logic [11:0]           in_csr,
    input  logic [4:0]            in_rs1_idx,
    input  logic [REG_WIDTH-1:0]  in_rs1_val,
    input  logic [4:0]            in_rd_idx,
    input  logic                  flush,
    output logic [1:0]            csr_op,
    output logic [2:0]            csr_funct3,
    output logic [4:0]            csr_imm,
    output logic [REG_WIDTH-1:0]  rs1_val,
    output logic [ADDR_WIDTH-1:0] csr_addr,
    output logic                  csr_valid,
    input  logic [ADDR_WIDTH-1:0] csr_rdata,
    input  logic                  csr_rvalid,
    input  logic                  csr_reg_rsp,
    output logic                  csr_rrsp,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic                  wb_rd_we,
    output logic [4:0]            wb_rd_idx,
    output logic [REG_WIDTH-1:0]  wb_data,
    output logic                  wb_exc
);

    state_t state, state_nx;
    logic [1:0] dec_op;
    logic       dec_ill;
    logic       accept;
    logic       rsp_take;
    logic       to_hit;
    logic       kill;

    csr_op_decode u_dec (
        .funct3  (in_funct3),
        .rs1_idx (in_rs1_idx),
        .rd_idx  (in_rd_idx),
        .op      (dec_op),
        .illegal (dec_ill)
    );

    assign accept   = in_valid & ~flush & (state == IDLE);
    assign rsp_take = (state == BUSY) & csr_rvalid;

`ifdef CSR_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
    logic [15:0] to_cnt;

    // A response in the limit cycle takes priority over the watchdog
    assign to_hit = (state == BUSY) & ~csr_rvalid & (to_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= 16'd0;
        end else if (accept) begin
            to_cnt <= 16'd0;
        end else if (state == BUSY && !csr_rvalid) begin
            to_cnt <= to_cnt + 16'd1;
        end
    end
`else
    logic unused_to;
    assign unused_to = (TIMEOUT_CYC == 0);
    assign to_hit    = 1'b0;
`endif

    logic unused_rdata;
    assign unused_rdata = ^csr_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            csr_op     <= 2'b00;
            csr_funct3 <= 3'd0;
            csr_imm    <= 5'd0;
            rs1_val    <= '0;
            csr_addr   <= '0;
            wb_rd_idx  <= 5'd0;
            wb_data    <= '0;
            wb_exc     <= 1'b0;
            wb_rd_we   <= 1'b0;
            kill       <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                csr_op     <= dec_ill ? 2'b00 : dec_op;
                csr_funct3 <= in_funct3;
                csr_imm    <= in_rs1_idx;
                rs1_val    <= in_rs1_val;
                csr_addr   <= {{(ADDR_WIDTH-12){1'b0}}, in_csr};
                wb_rd_idx  <= in_rd_idx;
                wb_data    <= '0;
                wb_exc     <= dec_ill;
                wb_rd_we   <= 1'b0;
                kill       <= 1'b0;
            end
            // Side effects may already be committed, so flush marks rather than aborts
            if (state == BUSY && flush) begin
                kill <= 1'b1;
            end
            if (rsp_take) begin
                wb_data  <= csr_rdata[REG_WIDTH-1:0];
                wb_exc   <= csr_reg_rsp;
                wb_rd_we <= csr_op[OP_R] & ~csr_reg_rsp & (wb_rd_idx != 5'd0);
            end else if (to_hit) begin
                wb_exc   <= 1'b1;
                wb_rd_we <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        csr_valid = 1'b0;
        csr_rrsp  = 1'b0;
        wb_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (accept) begin
                    state_nx = dec_ill ? RESP : BUSY;
                end
            end
            BUSY: begin
                csr_valid = 1'b1;
                csr_rrsp  = csr_rvalid;
                if (rsp_take || to_hit) begin
                    state_nx = (kill || flush) ? IDLE : RESP;
                end
            end
            RESP: begin
                wb_valid = 1'b1;
                if (wb_ready || flush) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_csr_req_ctrl.sv
// tb/tb_csr_req_ctrl.sv - randomized self-checking bench for csr_req_ctrl
module tb_csr_req_ctrl;

    localparam int AW = 32;
    localparam int RW = 32;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_funct3;
    logic [11:0]   in_csr;
    logic [4:0]    in_rs1_idx;
    logic [RW-1:0] in_rs1_val;
    logic [4:0]    in_rd_idx;
    logic          flush;
    logic [1:0]    csr_op;
    logic [2:0]    csr_funct3;
    logic [4:0]    csr_imm;
    logic [RW-1:0] rs1_val;
    logic [AW-1:0] csr_addr;
    logic          csr_valid;
    logic [AW-1:0] csr_rdata;
    logic          csr_rvalid;
    logic          csr_reg_rsp;
    logic          csr_rrsp;
    logic          wb_valid;
    logic          wb_ready;
    logic          wb_rd_we;
    logic [4:0]    wb_rd_idx;
    logic [RW-1:0] wb_data;
    logic          wb_exc;

    int total = 0;
    int bad   = 0;

    csr_req_ctrl #(.ADDR_WIDTH(AW), .REG_WIDTH(RW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
        .in_csr(in_csr), .in_rs1_idx(in_rs1_idx), .in_rs1_val(in_rs1_val),
        .in_rd_idx(in_rd_idx), .flush(flush),
        .csr_op(csr_op), .csr_funct3(csr_funct3), .csr_imm(csr_imm),
        .rs1_val(rs1_val), .csr_addr(csr_addr), .csr_valid(csr_valid),
        .csr_rdata(csr_rdata), .csr_rvalid(csr_rvalid), .csr_reg_rsp(csr_reg_rsp),
        .csr_rrsp(csr_rrsp),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd_we(wb_rd_we),
        .wb_rd_idx(wb_rd_idx), .wb_data(wb_data), .wb_exc(wb_exc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: read unless a write-only swap to x0; write unless a set/clear with zero source
    function automatic logic [1:0] model_op(input logic [2:0] f3, input logic [4:0] rs1i,
                                            input logic [4:0] rd);
        logic is_swap, is_setclr;
        is_swap   = (f3 == 3'b001) || (f3 == 3'b101);
        is_setclr = (f3 == 3'b010) || (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        if (is_swap)   return {rd != 5'd0, 1'b1};
        if (is_setclr) return {1'b1, rs1i != 5'd0};
        return 2'b00;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input logic [2:0] f3, input logic [11:0] csr, input logic [4:0] rs1i,
                           input logic [31:0] rs1v, input logic [4:0] rd, input int dly,
                           input logic [31:0] rdata, input logic rsp, input int flush_at,
                           input int hold, input bit flush_resp);
        logic [1:0] eop;
        logic       ill, killed, eexc, ewe;
        logic [31:0] edata;
        eop    = model_op(f3, rs1i, rd);
        ill    = (f3 == 3'b000) || (f3 == 3'b100);
        killed = 1'b0;
        in_valid = 1'b1; in_funct3 = f3; in_csr = csr; in_rs1_idx = rs1i;
        in_rs1_val = rs1v; in_rd_idx = rd;
        @(negedge clk);
        chk("in_ready_idle", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        in_funct3 = 3'($urandom); in_csr = 12'($urandom); in_rs1_val = $urandom;
        if (ill) begin
            chk("ill_no_req", csr_valid, 1'b0);
            eexc = 1'b1; ewe = 1'b0; edata = 32'd0;
        end else begin
            chk("req_valid", csr_valid, 1'b1);
            chk("req_op", csr_op, eop);
            chk("req_addr", csr_addr, {20'd0, csr});
            chk("req_f3", csr_funct3, f3);
            chk("req_imm", csr_imm, rs1i);
            chk("req_rs1", rs1_val, rs1v);
            for (int i = 0; i <= dly; i++) begin
                csr_rvalid  = (i == dly);
                csr_rdata   = (i == dly) ? rdata : 32'($urandom);
                csr_reg_rsp = (i == dly) ? rsp : 1'b0;
                flush       = (i == flush_at);
                if (i == flush_at) killed = 1'b1;
                @(negedge clk);
                chk("busy_valid", csr_valid, 1'b1);
                chk("busy_rrsp", csr_rrsp, (i == dly));
                chk("busy_in_ready", in_ready, 1'b0);
                chk("busy_op_stable", csr_op, eop);
                tick();
                csr_rvalid = 1'b0; flush = 1'b0; csr_reg_rsp = 1'b0;
            end
            eexc = rsp; ewe = eop[1] & ~rsp & (rd != 5'd0); edata = rdata;
        end
        if (killed) begin
            chk("kill_no_wb", wb_valid, 1'b0);
            chk("kill_in_ready", in_ready, 1'b1);
            return;
        end
        wb_ready = 1'b0;
        for (int h = 0; h <= hold; h++) begin
            chk("wb_valid", wb_valid, 1'b1);
            chk("wb_exc", wb_exc, eexc);
            chk("wb_we", wb_rd_we, ewe);
            chk("wb_idx", wb_rd_idx, rd);
            chk("wb_data", wb_data, edata);
            chk("resp_in_ready", in_ready, 1'b0);
            if (h < hold) tick();
        end
        if (flush_resp) flush = 1'b1;
        else wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0; flush = 1'b0;
        chk("done_wb_valid", wb_valid, 1'b0);
        chk("done_in_ready", in_ready, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_funct3 = 3'd0; in_csr = 12'd0; in_rs1_idx = 5'd0;
        in_rs1_val = '0; in_rd_idx = 5'd0; flush = 1'b0; csr_rdata = '0; csr_rvalid = 1'b0;
        csr_reg_rsp = 1'b0; wb_ready = 1'b0;
        #2;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_csr_valid", csr_valid, 1'b0);
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_csr_op", csr_op, 2'b00);
        chk("rst_addr", csr_addr, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        run_txn(3'b010, 12'h3A0, 5'd0, 32'h1234, 5'd5, 3, 32'h1F, 1'b0, -1, 0, 1'b0);
        run_txn(3'b001, 12'h300, 5'd7, 32'hDEAD_BEEF, 5'd0, 0, 32'h55, 1'b0, -1, 0, 1'b0);
        run_txn(3'b100, 12'h123, 5'd3, 32'h0, 5'd9, 0, 32'h0, 1'b0, -1, 0, 1'b0);
        run_txn(3'b110, 12'h340, 5'd4, 32'h0, 5'd6, 2, 32'hABCD, 1'b0, 1, 0, 1'b0);
        run_txn(3'b011, 12'h3EF, 5'd2, 32'h77, 5'd8, 1, 32'h99, 1'b1, -1, 4, 1'b0);

        // Flush while idle must block the offered instruction
        in_valid = 1'b1; flush = 1'b1; in_funct3 = 3'b010;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        chk("idle_flush_no_req", csr_valid, 1'b0);
        chk("idle_flush_no_wb", wb_valid, 1'b0);

        for (int n = 0; n < 60; n++) begin
            int dly, fa;
            dly = int'($urandom_range(0, 4));
            fa  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, dly)) : -1;
            run_txn(3'($urandom), 12'($urandom), 5'($urandom_range(0, 3) == 0 ? 0 : $urandom),
                    $urandom, 5'($urandom_range(0, 3) == 0 ? 0 : $urandom), dly, $urandom,
                    ($urandom_range(0, 4) == 0), fa, int'($urandom_range(0, 3)),
                    ($urandom_range(0, 6) == 0));
        end

        // Asynchronous reset in the middle of a request
        in_valid = 1'b1; in_funct3 = 3'b001; in_csr = 12'h305; in_rd_idx = 5'd1;
        tick();
        in_valid = 1'b0;
        chk("mid_rst_busy", csr_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_csr_valid", csr_valid, 1'b0);
        chk("mid_rst_in_ready", in_ready, 1'b1);
        chk("mid_rst_op", csr_op, 2'b00);
        chk("mid_rst_addr", csr_addr, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

`ifdef CSR_TIMEOUT_EN
        begin
            int n;
            in_valid = 1'b1; in_funct3 = 3'b010; in_csr = 12'h3A1; in_rd_idx = 5'd3;
            tick();
            in_valid = 1'b0;
            n = 0;
            while (!wb_valid && n < 4 * TO) begin
                tick();
                n++;
            end
            chk("to_cycles", n, TO);
            chk("to_exc", wb_exc, 1'b1);
            chk("to_we", wb_rd_we, 1'b0);
            chk("to_csr_valid", csr_valid, 1'b0);
            wb_ready = 1'b1;
            tick();
            wb_ready = 1'b0;
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
